// File: rtl/fuente_qos_pkg.sv
// rtl/fuente_qos_pkg.sv - shared parameters, FSM encoding and VC width helper for the qos link
package qos_pkg;

    localparam int QUEUE_QUANTITY = 4;
    localparam int BUF_WIDTH      = 3;
    localparam int CNT_W          = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ENVIAR = 2'd1,
        FIN    = 2'd2,
        ERROR  = 2'd3
    } state_t;

    // A single channel still needs a one-bit id field.
    function automatic int vc_w(input int q);
        return (q > 1) ? $clog2(q) : 1;
    endfunction

    localparam int VC_W = vc_w(QUEUE_QUANTITY);

endpackage

// File: rtl/fuente_qos_if.sv
// rtl/fuente_qos_if.sv - vc_id/data_word link between the traffic source and qos
interface fuente_qos_if import qos_pkg::*; #(
    parameter int QUEUE_QUANTITY = qos_pkg::QUEUE_QUANTITY,
    parameter int BUF_WIDTH      = qos_pkg::BUF_WIDTH
) ();
    localparam int VW = vc_w(QUEUE_QUANTITY);

    logic                      push;
    logic [VW-1:0]             vc_id;
    logic [BUF_WIDTH:0]        data_word;
    logic [QUEUE_QUANTITY-1:0] pausa;
    logic [QUEUE_QUANTITY-1:0] continuar;
    logic [QUEUE_QUANTITY-1:0] error_full;

    modport master (
        output push, vc_id, data_word,
        input  pausa, continuar, error_full
    );

    modport slave (
        input  push, vc_id, data_word,
        output pausa, continuar, error_full
    );

endinterface

// File: rtl/fuente_qos_arbitro_rr.sv
// rtl/fuente_qos_arbitro_rr.sv - combinational round-robin search starting after rr_ptr
module arbitro_rr import qos_pkg::*; #(
    parameter  int QUEUE_QUANTITY = qos_pkg::QUEUE_QUANTITY,
    localparam int VW             = vc_w(QUEUE_QUANTITY)
) (
    input  logic [QUEUE_QUANTITY-1:0] eligible,
    input  logic [VW-1:0]             rr_ptr,
    output logic [VW-1:0]             grant,
    output logic                      grant_valid
);

    always_comb begin
        logic [VW-1:0] idx;
        idx         = '0;
        grant       = '0;
        grant_valid = 1'b0;
        // Walk from the farthest candidate back so the nearest eligible one wins.
        for (int k = QUEUE_QUANTITY; k >= 1; k--) begin
            idx = VW'((int'(rr_ptr) + k) % QUEUE_QUANTITY);
            if (eligible[idx]) begin
                grant       = idx;
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fuente_qos.sv
// rtl/fuente_qos.sv - per-VC traffic source with round-robin arbitration and pausa/continuar flow control
module fuente_qos import qos_pkg::*; #(
    parameter int QUEUE_QUANTITY = qos_pkg::QUEUE_QUANTITY,
    parameter int BUF_WIDTH      = qos_pkg::BUF_WIDTH,
    parameter int CNT_W          = qos_pkg::CNT_W
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              enb,
    input  logic                              iniciar,
    input  logic [QUEUE_QUANTITY*CNT_W-1:0]   cantidad,
    fuente_qos_if.master                      link,
    output logic                              ocupado,
    output logic                              terminado,
    output logic                              error
);

    localparam int VW = vc_w(QUEUE_QUANTITY);
    localparam int DW = BUF_WIDTH + 1;

    state_t                    state, state_n;
    logic [CNT_W-1:0]          remaining [QUEUE_QUANTITY];
    logic [CNT_W-1:0]          rem_n     [QUEUE_QUANTITY];
    logic [DW-1:0]             seq       [QUEUE_QUANTITY];
    logic [DW-1:0]             seq_n     [QUEUE_QUANTITY];
    logic [QUEUE_QUANTITY-1:0] paused, paused_n, eligible;
    logic [VW-1:0]             rr_ptr, rr_n, grant, vc_q, vc_n;
    logic [DW-1:0]             dw_q, dw_n;
    logic                      grant_valid, push_q, push_n;
    logic                      ocupado_n, term_n, err_n, any_left;

    always_comb begin
        eligible = '0;
        for (int i = 0; i < QUEUE_QUANTITY; i++) begin
            eligible[i] = (remaining[i] != '0) && !paused[i] && !link.pausa[i];
        end
    end

    arbitro_rr #(.QUEUE_QUANTITY(QUEUE_QUANTITY)) u_arbitro (
        .eligible    (eligible),
        .rr_ptr      (rr_ptr),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    always_comb begin
        state_n   = state;
        rem_n     = remaining;
        seq_n     = seq;
        paused_n  = paused;
        rr_n      = rr_ptr;
        push_n    = 1'b0;
        vc_n      = vc_q;
        dw_n      = dw_q;
        term_n    = 1'b0;
        err_n     = error;
        any_left  = 1'b0;
        case (state)
            IDLE, ERROR: begin
                if (iniciar) begin
                    for (int i = 0; i < QUEUE_QUANTITY; i++) begin
                        rem_n[i] = cantidad[i*CNT_W +: CNT_W];
                        seq_n[i] = '0;
                    end
                    paused_n = '0;
                    err_n    = 1'b0;
                    state_n  = ENVIAR;
                end
            end
            ENVIAR: begin
                if (|link.error_full) begin
                    err_n   = 1'b1;
                    state_n = ERROR;
                end else begin
                    // pausa has priority over continuar on the same channel.
                    for (int i = 0; i < QUEUE_QUANTITY; i++) begin
                        if (link.pausa[i])          paused_n[i] = 1'b1;
                        else if (link.continuar[i]) paused_n[i] = 1'b0;
                    end
                    if (grant_valid) begin
                        push_n       = 1'b1;
                        vc_n         = grant;
                        dw_n         = seq[grant];
                        seq_n[grant] = seq[grant] + DW'(1);
                        rem_n[grant] = remaining[grant] - CNT_W'(1);
                        rr_n         = grant;
                    end
                    for (int i = 0; i < QUEUE_QUANTITY; i++) begin
                        if (rem_n[i] != '0) any_left = 1'b1;
                    end
                    if (!any_left) state_n = FIN;
                end
            end
            FIN: begin
                if (|link.error_full) begin
                    err_n   = 1'b1;
                    state_n = ERROR;
                end else begin
                    term_n  = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        ocupado_n = (state_n == ENVIAR);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            paused    <= '0;
            rr_ptr    <= VW'(QUEUE_QUANTITY - 1);
            push_q    <= 1'b0;
            vc_q      <= '0;
            dw_q      <= '0;
            ocupado   <= 1'b0;
            terminado <= 1'b0;
            error     <= 1'b0;
            for (int i = 0; i < QUEUE_QUANTITY; i++) begin
                remaining[i] <= '0;
                seq[i]       <= '0;
            end
        end else if (enb) begin
            state     <= state_n;
            paused    <= paused_n;
            rr_ptr    <= rr_n;
            push_q    <= push_n;
            vc_q      <= vc_n;
            dw_q      <= dw_n;
            ocupado   <= ocupado_n;
            terminado <= term_n;
            error     <= err_n;
            for (int i = 0; i < QUEUE_QUANTITY; i++) begin
                remaining[i] <= rem_n[i];
                seq[i]       <= seq_n[i];
            end
        end else begin
            push_q <= 1'b0;
        end
    end

    assign link.push      = push_q;
    assign link.vc_id     = vc_q;
    assign link.data_word = dw_q;

endmodule

// File: tb/tb_fuente_qos.sv
// tb/tb_fuente_qos.sv - directed self-checking bench for fuente_qos
module tb_fuente_qos;

    logic        clk;
    logic        rst;
    logic        enb;
    logic        iniciar;
    logic [15:0] cantidad;
    logic        ocupado;
    logic        terminado;
    logic        error;

    int vectors;
    int miscompares;

    fuente_qos_if #(.QUEUE_QUANTITY(4), .BUF_WIDTH(3)) link ();

    fuente_qos #(.QUEUE_QUANTITY(4), .BUF_WIDTH(3), .CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .enb       (enb),
        .iniciar   (iniciar),
        .cantidad  (cantidad),
        .link      (link),
        .ocupado   (ocupado),
        .terminado (terminado),
        .error     (error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst            = 1'b0;
        enb            = 1'b1;
        iniciar        = 1'b0;
        cantidad       = '0;
        link.pausa     = '0;
        link.continuar = '0;
        link.error_full = '0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic start(input logic [15:0] c);
        cantidad = c;
        iniciar  = 1'b1;
        tick();
        iniciar  = 1'b0;
    endtask

    task automatic test_reset();
        reset_dut();
        vectors++;
        if ({link.push, link.vc_id, link.data_word, ocupado, terminado, error} !== 10'd0) begin
            miscompares++;
            $display("FAIL reset_idle got push=%0b vc=%0d dw=%0d ocu=%0b term=%0b err=%0b want all 0",
                     link.push, link.vc_id, link.data_word, ocupado, terminado, error);
        end
        start(16'h0004);
        tick();
        tick();
        rst = 1'b0;
        #1;
        vectors++;
        if ({link.push, link.vc_id, link.data_word, ocupado, terminado, error} !== 10'd0) begin
            miscompares++;
            $display("FAIL reset_async got push=%0b vc=%0d dw=%0d ocu=%0b term=%0b err=%0b want all 0",
                     link.push, link.vc_id, link.data_word, ocupado, terminado, error);
        end
        rst = 1'b1;
        start(16'h0002);
        for (int k = 0; k < 2; k++) begin
            tick();
            vectors++;
            if ({link.push, link.vc_id, link.data_word} !== {1'b1, 2'd0, 4'(k)}) begin
                miscompares++;
                $display("FAIL reset_push%0d got push=%0b vc=%0d dw=%0d want 1/0/%0d",
                         k, link.push, link.vc_id, link.data_word, k);
            end
        end
        tick();
        vectors++;
        if ({link.push, terminado} !== 2'b01) begin
            miscompares++;
            $display("FAIL reset_term got push=%0b term=%0b want 0/1", link.push, terminado);
        end
        tick();
        vectors++;
        if (terminado !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_term_pulse got term=%0b want 0", terminado);
        end
    endtask

    task automatic test_round_robin();
        reset_dut();
        start(16'h1111);
        for (int k = 0; k < 4; k++) begin
            tick();
            vectors++;
            if ({link.push, link.vc_id, link.data_word} !== {1'b1, 2'(k), 4'd0}) begin
                miscompares++;
                $display("FAIL rr_push%0d got push=%0b vc=%0d dw=%0d want 1/%0d/0",
                         k, link.push, link.vc_id, link.data_word, k);
            end
            if (k < 3) begin
                vectors++;
                if (ocupado !== 1'b1) begin
                    miscompares++;
                    $display("FAIL rr_ocupado%0d got %0b want 1", k, ocupado);
                end
            end
        end
        tick();
        vectors++;
        if ({link.push, terminado} !== 2'b01) begin
            miscompares++;
            $display("FAIL rr_term got push=%0b term=%0b want 0/1", link.push, terminado);
        end
        tick();
        vectors++;
        if ({ocupado, terminado} !== 2'b00) begin
            miscompares++;
            $display("FAIL rr_done got ocu=%0b term=%0b want 0/0", ocupado, terminado);
        end
    endtask

    task automatic test_sequence();
        reset_dut();
        start(16'h00F0);
        for (int k = 0; k < 15; k++) begin
            tick();
            vectors++;
            if ({link.push, link.vc_id, link.data_word} !== {1'b1, 2'd1, 4'(k)}) begin
                miscompares++;
                $display("FAIL seq_push%0d got push=%0b vc=%0d dw=%0d want 1/1/%0d",
                         k, link.push, link.vc_id, link.data_word, k);
            end
        end
        tick();
        vectors++;
        if ({link.push, terminado} !== 2'b01) begin
            miscompares++;
            $display("FAIL seq_term got push=%0b term=%0b want 0/1", link.push, terminado);
        end
        tick();
        start(16'h0020);
        for (int k = 0; k < 2; k++) begin
            tick();
            vectors++;
            if ({link.push, link.vc_id, link.data_word} !== {1'b1, 2'd1, 4'(k)}) begin
                miscompares++;
                $display("FAIL seq_restart%0d got push=%0b vc=%0d dw=%0d want 1/1/%0d",
                         k, link.push, link.vc_id, link.data_word, k);
            end
        end
    endtask

    task automatic test_flow_control();
        reset_dut();
        link.pausa = 4'b0001;
        start(16'h0022);
        for (int k = 0; k < 2; k++) begin
            tick();
            vectors++;
            if ({link.push, link.vc_id, link.data_word} !== {1'b1, 2'd1, 4'(k)}) begin
                miscompares++;
                $display("FAIL fc_vc1_%0d got push=%0b vc=%0d dw=%0d want 1/1/%0d",
                         k, link.push, link.vc_id, link.data_word, k);
            end
        end
        tick();
        vectors++;
        if (link.push !== 1'b0) begin
            miscompares++;
            $display("FAIL fc_blocked got push=%0b want 0", link.push);
        end
        link.continuar = 4'b0001;
        tick();
        link.pausa     = 4'b0000;
        link.continuar = 4'b0000;
        tick();
        vectors++;
        if ({link.push, ocupado} !== 2'b01) begin
            miscompares++;
            $display("FAIL fc_pausa_wins got push=%0b ocu=%0b want 0/1", link.push, ocupado);
        end
        link.continuar = 4'b0001;
        tick();
        link.continuar = 4'b0000;
        vectors++;
        if (link.push !== 1'b0) begin
            miscompares++;
            $display("FAIL fc_resume_edge got push=%0b want 0", link.push);
        end
        for (int k = 0; k < 2; k++) begin
            tick();
            vectors++;
            if ({link.push, link.vc_id, link.data_word} !== {1'b1, 2'd0, 4'(k)}) begin
                miscompares++;
                $display("FAIL fc_vc0_%0d got push=%0b vc=%0d dw=%0d want 1/0/%0d",
                         k, link.push, link.vc_id, link.data_word, k);
            end
        end
        tick();
        vectors++;
        if ({link.push, terminado} !== 2'b01) begin
            miscompares++;
            $display("FAIL fc_term got push=%0b term=%0b want 0/1", link.push, terminado);
        end
    endtask

    task automatic test_error();
        reset_dut();
        start(16'h0033);
        tick();
        tick();
        vectors++;
        if ({link.push, link.vc_id, link.data_word} !== {1'b1, 2'd1, 4'd0}) begin
            miscompares++;
            $display("FAIL err_pre got push=%0b vc=%0d dw=%0d want 1/1/0",
                     link.push, link.vc_id, link.data_word);
        end
        link.error_full = 4'b0100;
        tick();
        link.error_full = 4'b0000;
        vectors++;
        if ({link.push, error, ocupado} !== 3'b010) begin
            miscompares++;
            $display("FAIL err_set got push=%0b err=%0b ocu=%0b want 0/1/0", link.push, error, ocupado);
        end
        tick();
        tick();
        vectors++;
        if ({link.push, error, ocupado} !== 3'b010) begin
            miscompares++;
            $display("FAIL err_hold got push=%0b err=%0b ocu=%0b want 0/1/0", link.push, error, ocupado);
        end
        start(16'h0100);
        vectors++;
        if ({error, ocupado} !== 2'b01) begin
            miscompares++;
            $display("FAIL err_clear got err=%0b ocu=%0b want 0/1", error, ocupado);
        end
        tick();
        vectors++;
        if ({link.push, link.vc_id, link.data_word} !== {1'b1, 2'd2, 4'd0}) begin
            miscompares++;
            $display("FAIL err_reload got push=%0b vc=%0d dw=%0d want 1/2/0",
                     link.push, link.vc_id, link.data_word);
        end
        tick();
        vectors++;
        if ({link.push, terminado} !== 2'b01) begin
            miscompares++;
            $display("FAIL err_term got push=%0b term=%0b want 0/1", link.push, terminado);
        end
    endtask

    task automatic test_enable();
        reset_dut();
        start(16'h0004);
        tick();
        tick();
        enb = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            vectors++;
            if ({link.push, link.data_word} !== {1'b0, 4'd1}) begin
                miscompares++;
                $display("FAIL enb_freeze%0d got push=%0b dw=%0d want 0/1", k, link.push, link.data_word);
            end
        end
        enb = 1'b1;
        for (int k = 2; k < 4; k++) begin
            tick();
            vectors++;
            if ({link.push, link.vc_id, link.data_word} !== {1'b1, 2'd0, 4'(k)}) begin
                miscompares++;
                $display("FAIL enb_resume%0d got push=%0b vc=%0d dw=%0d want 1/0/%0d",
                         k, link.push, link.vc_id, link.data_word, k);
            end
        end
        tick();
        vectors++;
        if ({link.push, terminado} !== 2'b01) begin
            miscompares++;
            $display("FAIL enb_term got push=%0b term=%0b want 0/1", link.push, terminado);
        end
    endtask

    task automatic test_zero_counts();
        reset_dut();
        start(16'h0000);
        tick();
        vectors++;
        if ({link.push, terminado} !== 2'b00) begin
            miscompares++;
            $display("FAIL zero_enviar got push=%0b term=%0b want 0/0", link.push, terminado);
        end
        tick();
        vectors++;
        if ({link.push, terminado} !== 2'b01) begin
            miscompares++;
            $display("FAIL zero_term got push=%0b term=%0b want 0/1", link.push, terminado);
        end
    endtask

    initial begin
        vectors         = 0;
        miscompares     = 0;
        rst             = 1'b1;
        enb             = 1'b1;
        iniciar         = 1'b0;
        cantidad        = '0;
        link.pausa      = '0;
        link.continuar  = '0;
        link.error_full = '0;
        #2;
        test_reset();
        test_round_robin();
        test_sequence();
        test_flow_control();
        test_error();
        test_enable();
        test_zero_counts();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fuente_qos.md
Name: fuente_qos

Overview:
Traffic source and flow-control responder for the qos block; it is the writer side of the vc_id/data_word interface.
- Sends a programmed number of words per virtual channel, arbitrating round-robin across channels.
- Honours the per-channel pausa/continuar flow control that qos emits.
- Stops on error_full.
- Used as stimulus generator in qos benches and as the upstream model in system sims.

Parameters:
QUEUE_QUANTITY, 4, number of virtual channels / qos FIFOs
BUF_WIDTH, 3, data_word is BUF_WIDTH+1 bits wide
CNT_W, 4, width of per-channel word-count field

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
enb  input  1  global enable; low freezes all state
iniciar  input  1  start pulse, sampled only in IDLE
cantidad  input  QUEUE_QUANTITY*CNT_W  words to send per VC; VC i at bits [i*CNT_W +: CNT_W]
pausa  input  QUEUE_QUANTITY  per-VC pause request from qos
continuar  input  QUEUE_QUANTITY  per-VC resume request from qos
error_full  input  QUEUE_QUANTITY  per-VC overflow indication from qos
push  output  1  data_word/vc_id valid this cycle
vc_id  output  $clog2(QUEUE_QUANTITY)  target channel
data_word  output  BUF_WIDTH+1  payload
ocupado  output  1  high in ENVIAR
terminado  output  1  one-cycle pulse when all counts are exhausted
error  output  1  sticky; set on any error_full bit

Behaviour:
- Reset values (rst=0, async): push=0, vc_id=0, data_word=0, ocupado=0, terminado=0, error=0, state=IDLE, remaining counts=0, paused flags=0, sequence counters=0, rr pointer = QUEUE_QUANTITY-1 (so VC0 is served first).
- All outputs are registered.
- enb=0: no state or output change except push, which is forced to 0 at the next edge. Async reset still acts.
- FSM states: IDLE, ENVIAR, FIN, ERROR.
- IDLE:
  - iniciar=1 at edge N: load remaining[i] from cantidad, clear sequence counters and paused flags, clear error, go to ENVIAR.
  - First push is possible at edge N+1.
- ENVIAR:
  - eligible[i] = remaining[i]!=0 && !paused[i] && !pausa[i].
  - Pick the first eligible VC searching from rr_ptr+1 upward, with wrap-around.
  - If one is found: push=1, vc_id=i, data_word=seq[i] (low BUF_WIDTH+1 bits), then seq[i]++, remaining[i]--, rr_ptr=i.
  - If none is eligible: push=0.
  - Throughput is at most one word per cycle.
  - iniciar is ignored.
- Flow control, per VC:
  - pausa[i] sets paused[i].
  - continuar[i] clears paused[i]; the VC becomes eligible the next cycle.
  - pausa and continuar both high: pausa wins.
  - pausa also blocks combinationally in the same cycle.
- ENVIAR exit to FIN: when every remaining[i] is 0 after the current push.
- FIN: terminado=1 for exactly one cycle, push=0, then IDLE.
- If all cantidad fields are 0 at iniciar: ENVIAR lasts one cycle with no push, then FIN.
- error_full: any bit high in ENVIAR or FIN →
  - error=1 at the next edge, push=0 that edge, state=ERROR;
  - ERROR holds with push=0 and ocupado=0;
  - iniciar leaves ERROR through the IDLE load path, clears error and reloads counts.
- Counters:
  - seq[i] wraps modulo 2^(BUF_WIDTH+1).
  - remaining never underflows (decrement only when nonzero).
- Reset mid-operation abandons the transfer immediately; no partial state survives.

Decomposition:
- Package qos_pkg holds:
  - QUEUE_QUANTITY, BUF_WIDTH, CNT_W defaults;
  - state encoding localparams IDLE=0, ENVIAR=1, FIN=2, ERROR=3;
  - the VC id width expression.
- One sub-module: arbitro_rr.
  - Inputs: eligible vector and rr pointer.
  - Outputs: grant index and grant_valid.
  - Combinational round-robin search, reusable by the qos side.

Test Plan:
- Reset: rst=0 during activity → all outputs 0 immediately. rst=1, then iniciar with cantidad VC0=2 → pushes (VC0, 0), (VC0, 1), then terminado pulse.
- Round-robin: cantidad VC3..0 = 1,1,1,1, iniciar at edge N → pushes on N+1..N+4 with vc_id 0,1,2,3, each data_word 0; terminado at N+5; ocupado low from N+6.
- Sequence and wrap: cantidad VC1=15 only → 15 consecutive pushes, vc_id=1, data_word 0..14. A second iniciar (counters cleared) restarts at data_word 0.
- Flow control:
  - Setup: cantidad VC0=2, VC1=2; hold pausa[0]=1 from before iniciar.
  - Only VC1 words go out, then push=0.
  - continuar[0] pulse → VC0 words 0 and 1 go out starting the cycle after next; then terminado.
  - Simultaneous pausa[0]=continuar[0]=1 → VC0 stays paused.
- Error: error_full[2]=1 mid-transfer → push=0 next edge, error=1 held, ocupado=0. iniciar → error=0 and the transfer restarts from the reloaded cantidad.
- Enable: enb=0 for 3 cycles after the second push of a cantidad VC0=4 run → no pushes, data_word unchanged. enb=1 → data_word 2, then 3, then terminado.
